// File: rtl/uart_tx_feeder.sv
// Byte FIFO feeding a UART TX state machine through a start/tx_done handshake.
// Optional sticky overflow flag is compiled in with UART_TX_FEEDER_OVF_EN.
module uart_tx_feeder #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     in_ready,
    output logic                     start,
    output logic [DATA_W-1:0]        tx_data,
    input  logic                     tx_done,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty,
    output logic                     full,
    input  logic                     ovf_clr,
    output logic                     overflow,
    output logic [1:0]               o_dbg_state
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);

    // Host side: in_valid/in_ready; a byte moves on any rising edge where both are high.
    // TX side: start rises with tx_data stable; tx_done high pops the byte, start
    // drops, and no new start is issued until tx_done returns low.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SEND    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [AW:0]         r_level;
    logic                r_start;
    logic [DATA_W-1:0]   r_tx_data;
    logic                r_ovf;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;

    assign w_full   = (r_level == L_DEPTH);
    assign w_empty  = (r_level == '0);
    assign w_push   = in_valid && !w_full;
    assign w_pop    = (r_state == S_SEND) && tx_done;

    assign in_ready    = !w_full;
    assign full        = w_full;
    assign empty       = w_empty;
    assign level       = r_level;
    assign start       = r_start;
    assign tx_data     = r_tx_data;
    assign overflow    = r_ovf;
    assign o_dbg_state = r_state;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_start   <= 1'b0;
            r_tx_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_state   <= S_SEND;
                        r_start   <= 1'b1;
                        r_tx_data <= r_mem[r_rd_ptr];
                    end
                end
                S_SEND: begin
                    if (tx_done) begin
                        r_state <= S_RELEASE;
                        r_start <= 1'b0;
                    end
                end
                S_RELEASE: begin
                    if (!tx_done) r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_start <= 1'b0;
                end
            endcase
        end
    end

`ifdef UART_TX_FEEDER_OVF_EN
    // A dropped write on the same edge as a clear wins, so no drop goes unreported.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (in_valid && w_full) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end
`else
    logic w_ovf_clr_unused;
    assign w_ovf_clr_unused = ovf_clr;
    assign r_ovf = 1'b0;
`endif

endmodule

// File: doc/uart_tx_feeder.md
UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of FIFO entries (power of two, 2..64).
REQ-002 SHALL have parameter DATA_W, default 8, width of each byte entry.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  host offers in_data.
REQ-006 SHALL have port in_data  input  DATA_W  host byte to transmit.
REQ-007 SHALL have port in_ready  output  1  FIFO can accept a byte this cycle.
REQ-008 SHALL have port start  output  1  request to the TX state machine to send tx_data.
REQ-009 SHALL have port tx_data  output  DATA_W  byte presented to the TX datapath.
REQ-010 SHALL have port tx_done  input  1  TX state machine completion flag, held high until start drops.
REQ-011 SHALL have port level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-012 SHALL have ports empty and full  output  1 each  occupancy flags.
REQ-013 SHALL have port ovf_clr  input  1  clears the overflow flag.
REQ-014 SHALL have port overflow  output  1  sticky dropped-write flag.

Function
REQ-015 SHALL push in_data when in_valid and in_ready are both high at a rising edge; in_ready SHALL equal !full combinationally.
REQ-016 SHALL implement a circular buffer with read/write pointers wrapping from DEPTH-1 to 0; level SHALL range 0..DEPTH; empty = (level==0), full = (level==DEPTH).
REQ-017 SHALL run a registered FSM with states IDLE, SEND, RELEASE; start SHALL be high only in SEND.
REQ-018 IDLE -> SEND when !empty; on this transition tx_data SHALL be loaded with the FIFO head and held stable until the next IDLE -> SEND transition.
REQ-019 SEND -> RELEASE when tx_done is sampled high; the head entry SHALL be popped on that same edge.
REQ-020 RELEASE -> IDLE when tx_done is sampled low; no new start SHALL be issued while tx_done is high.
REQ-021 A byte pushed into an empty FIFO in IDLE at edge N SHALL produce start high after edge N+1, i.e. 1-cycle latency from write to start.
REQ-022 Simultaneous push and pop on one edge SHALL both take effect, with level unchanged.
REQ-023 Writes offered while full SHALL be dropped without corrupting contents or pointers.
REQ-024 Back-to-back bytes SHALL be separated by at least one cycle of start low (the RELEASE state).

Reset
REQ-025 rst_n low SHALL asynchronously force state IDLE, pointers 0, level 0, empty 1, full 0, start 0, tx_data 0, overflow 0.
REQ-026 Reset mid-transfer SHALL discard all queued bytes, including the byte in flight; no start SHALL be issued until a new push after reset release.

Configuration
REQ-027 With macro UART_TX_FEEDER_OVF_EN defined, overflow SHALL set on any edge where in_valid is high and full is high, stay set until an edge with ovf_clr high, and set take priority over clear on the same edge.
REQ-028 Without UART_TX_FEEDER_OVF_EN, overflow SHALL be tied 0 and ovf_clr SHALL be ignored; all other behaviour SHALL be identical.

Verification
REQ-029 Single byte: push 0xA5 into an empty FIFO -> start high 1 cycle later with tx_data=0xA5; tx_done pulse high for 3 cycles -> start low, level 0, return to IDLE after tx_done falls.
REQ-030 Ordering: push 0x01,0x02,0x03 back-to-back -> tx_data sequence 0x01,0x02,0x03, with start low for at least 1 cycle between transfers.
REQ-031 Full/overflow: push 9 bytes 0x10..0x18 with DEPTH=8 and tx_done held low -> level 8, full 1, in_ready 0, 0x18 dropped; overflow=1 only with UART_TX_FEEDER_OVF_EN; ovf_clr pulse -> overflow 0.
REQ-032 Simultaneous push/pop: at level 4, push 0x55 on the same edge as a tx_done-driven pop -> level stays 4, 0x55 is sent last.
REQ-033 Wrap-around: push/pop 20 bytes 0x00..0x13 through a DEPTH=8 FIFO -> all transmitted in order, no loss or duplication.
REQ-034 Reset mid-transfer: assert rst_n low during SEND with level 3 -> start 0 immediately, level 0, empty 1; after release no start until a new push.
